// File: rtl/halton_point_collector.sv
// Requester for the Halton point generator: issues pop/reseed pulses, captures points
// into a FIFO and streams them out. Define HALTON_COLLECT_TIMEOUT_EN for the response timeout.
module halton_point_collector #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 8,
   parameter int TMO_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      count,
   input  logic [31:0]      seed,
   input  logic             reseed_req,
   output logic             gen_pop_enable,
   output logic [31:0]      gen_seed,
   output logic             gen_reseed_enable,
   input  logic [WIDTH-1:0] gen_out_0,
   input  logic [WIDTH-1:0] gen_out_1,
   input  logic             gen_valid,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_x,
   output logic [WIDTH-1:0] m_y,
   output logic             busy,
   output logic             done,
   output logic             tmo_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYCLES < 1) begin : g_param_check
      $error("halton_point_collector: DEPTH must be a power of two >= 2, TMO_CYCLES >= 1");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RESEED = 3'd1,
      ISSUE  = 3'd2,
      WAIT   = 3'd3,
      FINISH = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic [15:0]        remaining;
   logic               gen_valid_q;
   logic               gv_edge;
   logic               push;
   logic               pop;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_next;
   logic [PW-1:0]      rd_next;
   logic               full_next;
   logic               empty_next;
   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [2*WIDTH-1:0] push_data;
   logic [2*WIDTH-1:0] head_next;
   logic               tmo_hit;
   logic               pop_d;
   logic               reseed_d;
   logic               done_d;
   logic               busy_d;

   assign gv_edge   = gen_valid & ~gen_valid_q;
   assign push      = (state == WAIT) & gv_edge;
   assign pop       = m_valid & m_ready;
   assign push_data = {gen_out_0, gen_out_1};
   assign wr_next   = wr_ptr + PW'(push);
   assign rd_next   = rd_ptr + PW'(pop);

   assign full_next  = (wr_next[AW] != rd_next[AW]) && (wr_next[AW-1:0] == rd_next[AW-1:0]);
   assign empty_next = (wr_next == rd_next);

   // A push into an empty-after-pop FIFO lands at the new head, so bypass the array read.
   always_comb begin
      head_next = mem[rd_next[AW-1:0]];
      if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
         head_next = push_data;
      end
   end

`ifdef HALTON_COLLECT_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = (state == WAIT) && !gv_edge && (tmo_cnt == TW'(TMO_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         if (state != WAIT) begin
            tmo_cnt <= '0;
         end else if (!gv_edge) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end
         if (state == IDLE && start) begin
            tmo_err <= 1'b0;
         end else if (tmo_hit) begin
            tmo_err <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign tmo_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ISSUE leaves only once its registered pop pulse has been presented.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (count == 16'd0) begin
                  next_state = FINISH;
               end else if (reseed_req) begin
                  next_state = RESEED;
               end else begin
                  next_state = ISSUE;
               end
            end
         end
         RESEED: next_state = ISSUE;
         ISSUE: begin
            if (gen_pop_enable) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (tmo_hit) begin
               next_state = FINISH;
            end else if (push) begin
               next_state = (remaining == 16'd1) ? FINISH : ISSUE;
            end
         end
         FINISH:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      pop_d    = (next_state == ISSUE) && !full_next;
      reseed_d = (next_state == RESEED);
      done_d   = (next_state == FINISH);
      busy_d   = (next_state != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gen_pop_enable    <= 1'b0;
         gen_reseed_enable <= 1'b0;
         done              <= 1'b0;
         busy              <= 1'b0;
         gen_seed          <= '0;
         remaining         <= '0;
         gen_valid_q       <= 1'b0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         m_valid           <= 1'b0;
         m_x               <= '0;
         m_y               <= '0;
      end else begin
         gen_pop_enable    <= pop_d;
         gen_reseed_enable <= reseed_d;
         done              <= done_d;
         busy              <= busy_d;
         gen_valid_q       <= gen_valid;
         wr_ptr            <= wr_next;
         rd_ptr            <= rd_next;
         m_valid           <= !empty_next;
         m_x               <= head_next[2*WIDTH-1:WIDTH];
         m_y               <= head_next[WIDTH-1:0];
         if (state == IDLE && start) begin
            remaining <= count;
            gen_seed  <= seed;
         end else if (push) begin
            remaining <= remaining - 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule
